// File: rtl/blink_controller.sv
// ---------------------------------------------------------------------------
// blink_controller
//
// Accepts a blink job (on length, off length, period count) through a
// valid/ready handshake. It then drives a registered blink waveform for the
// requested number of on/off periods, and pulses done for one cycle at the
// end. Requests that arrive while a job is running are dropped, not queued.
//
// Optional feature: define BLINK_CONTROLLER_ABORT_EN to add an abort input.
// abort ends a running job early: the job goes through DONE, so done still
// pulses.
//
// Ports
//   clock        : single clock, all state on its rising edge
//   reset_n      : asynchronous active-low reset
//   start_valid  : a job request is present
//   start_ready  : block can accept a job (high only in IDLE)
//   on_cycles    : high-phase length in cycles (0 is treated as 1)
//   off_cycles   : low-phase length in cycles (0 is treated as 1)
//   repeats      : number of on/off periods (0 goes straight to DONE)
//   blinker      : registered blink output, high only in ON
//   busy         : job in progress (ON, OFF or DONE)
//   done         : one-cycle pulse in DONE
//   abort        : (BLINK_CONTROLLER_ABORT_EN only) end the running job early
// ---------------------------------------------------------------------------
module blink_controller #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] on_cycles,
    input  logic [CNT_W-1:0] off_cycles,
    input  logic [REP_W-1:0] repeats,
    output logic             blinker,
    output logic             busy,
    output logic             done
`ifdef BLINK_CONTROLLER_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] phase_q,   phase_d;
    logic [REP_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] on_len_q,  on_len_d;
    logic [CNT_W-1:0] off_len_q, off_len_d;
    logic             blinker_q, blinker_d;
    logic             abort_hit;

    // The phase counter holds the number of cycles still to go after the
    // current one. A length of 0 is clamped to 1, so both 0 and 1 load 0.
    // The maximum length 2^CNT_W-1 loads 2^CNT_W-2, so no extra counter bit
    // is needed.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

`ifdef BLINK_CONTROLLER_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        period_d  = period_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    on_len_d  = on_cycles;
                    off_len_d = off_cycles;
                    period_d  = repeats;
                    phase_d   = len_m1(on_cycles);
                    state_d   = (repeats == '0) ? DONE : ON;
                end
            end
            ON: begin
                // abort wins over a phase ending in the same cycle
                if (abort_hit) begin
                    state_d = DONE;
                end else if (phase_q == '0) begin
                    phase_d = len_m1(off_len_q);
                    state_d = OFF;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            OFF: begin
                if (abort_hit) begin
                    state_d = DONE;
                end else if (phase_q == '0) begin
                    // A period ends here. Go back to ON with no gap cycle,
                    // or finish if this was the last period.
                    period_d = period_q - 1'b1;
                    if (period_q == REP_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        phase_d = len_m1(on_len_q);
                        state_d = ON;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // blinker is registered from the next state, so it lines up exactly
        // with the ON state and does not lag it.
        blinker_d = (state_d == ON);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            period_q  <= '0;
            on_len_q  <= '0;
            off_len_q <= '0;
            blinker_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            blinker_q <= blinker_d;
        end
    end

    assign blinker     = blinker_q;
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_blink_controller.sv
// ---------------------------------------------------------------------------
// tb_blink_controller
//
// A table of jobs (on, off, repeats, and a hand-computed done cycle counted
// from the accept edge) is run back to back. Every cycle of every job is
// checked against the expected waveform. During each job the bench changes
// the inputs and pulses start_valid, which the DUT must ignore.
// Hand-written sequences cover three further cases: repeats=0 with
// start_valid held high, reset during OFF, and (with
// BLINK_CONTROLLER_ABORT_EN) abort.
// ---------------------------------------------------------------------------
module tb_blink_controller;

    localparam int CNT_W = 6;
    localparam int REP_W = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start_valid;
    logic             start_ready;
    logic [CNT_W-1:0] on_cycles;
    logic [CNT_W-1:0] off_cycles;
    logic [REP_W-1:0] repeats;
    logic             blinker;
    logic             busy;
    logic             done;
`ifdef BLINK_CONTROLLER_ABORT_EN
    logic             abort;
`endif

    int n_pass  = 0;
    int n_total = 0;

    blink_controller #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .on_cycles   (on_cycles),
        .off_cycles  (off_cycles),
        .repeats     (repeats),
        .blinker     (blinker),
        .busy        (busy),
        .done        (done)
`ifdef BLINK_CONTROLLER_ABORT_EN
        ,
        .abort       (abort)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int on;
        int off;
        int rep;
        int exp_done;  // edge after accept on which done is high
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for IDLE. If the bound runs out, that counts as a failure.
    task automatic wait_idle(input int budget);
        int n = 0;
        while (!start_ready && n < budget) begin
            step();
            n++;
        end
        check("wait_idle", int'(start_ready), 1);
    endtask

    task automatic run_job(input vec_t v);
        int eon, eoff, per, exp_b;
        eon  = (v.on  == 0) ? 1 : v.on;
        eoff = (v.off == 0) ? 1 : v.off;
        per  = eon + eoff;
        on_cycles   = CNT_W'(v.on);
        off_cycles  = CNT_W'(v.off);
        repeats     = REP_W'(v.rep);
        start_valid = 1'b1;
        check("accept_ready", int'(start_ready), 1);
        check("accept_blinker", int'(blinker), 0);
        step();
        // Change the inputs after the accept; the running job must not see it.
        start_valid = 1'b0;
        on_cycles   = CNT_W'($urandom);
        off_cycles  = CNT_W'($urandom);
        repeats     = REP_W'($urandom);
        for (int k = 1; k <= v.exp_done; k++) begin
            exp_b = (k <= v.rep * per && ((k - 1) % per) < eon) ? 1 : 0;
            check($sformatf("job%0d/%0d/%0d blinker k=%0d", v.on, v.off, v.rep, k), int'(blinker), exp_b);
            check($sformatf("job%0d/%0d/%0d done k=%0d", v.on, v.off, v.rep, k), int'(done), (k == v.exp_done) ? 1 : 0);
            check($sformatf("job%0d/%0d/%0d busy k=%0d", v.on, v.off, v.rep, k), int'(busy), 1);
            // Pulse start_valid mid-job; the DUT must ignore it.
            start_valid = (k == 3) ? 1'b1 : 1'b0;
            step();
        end
        start_valid = 1'b0;
        check("post_job_ready", int'(start_ready), 1);
        check("post_job_busy", int'(busy), 0);
        check("post_job_done", int'(done), 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{on: 10, off: 10, rep: 20, exp_done: 401};
        vecs[1] = '{on: 0,  off: 3,  rep: 2,  exp_done: 9};
        vecs[2] = '{on: 0,  off: 0,  rep: 1,  exp_done: 3};
        vecs[3] = '{on: 3,  off: 1,  rep: 2,  exp_done: 9};
        vecs[4] = '{on: 1,  off: 2,  rep: 3,  exp_done: 10};
        vecs[5] = '{on: 63, off: 63, rep: 1,  exp_done: 127};

        reset_n     = 1'b0;
        start_valid = 1'b0;
        on_cycles   = '0;
        off_cycles  = '0;
        repeats     = '0;
`ifdef BLINK_CONTROLLER_ABORT_EN
        abort       = 1'b0;
`endif
        #12;
        check("rst_blinker", int'(blinker), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(start_ready), 1);

        // Release reset away from an edge. The first job is accepted on the
        // very next rising edge.
        @(negedge clock);
        reset_n = 1'b1;
        foreach (vecs[i]) run_job(vecs[i]);

        // repeats=0 with start_valid held high: done comes on the next cycle,
        // and no accept happens until after DONE.
        on_cycles   = 6'd2;
        off_cycles  = 6'd2;
        repeats     = 8'd0;
        start_valid = 1'b1;
        step();
        check("rep0_done", int'(done), 1);
        check("rep0_blinker", int'(blinker), 0);
        check("rep0_ready_in_done", int'(start_ready), 0);
        on_cycles  = 6'd1;
        off_cycles = 6'd1;
        repeats    = 8'd1;
        step();
        check("rep0_back_idle_done", int'(done), 0);
        check("rep0_back_idle_ready", int'(start_ready), 1);
        check("rep0_no_accept_in_done", int'(blinker), 0);
        step();
        check("rep0_next_accept_blinker", int'(blinker), 1);
        start_valid = 1'b0;
        wait_idle(20);

        // Reset while the first period of a 5/5/4 job is in OFF.
        on_cycles   = 6'd5;
        off_cycles  = 6'd5;
        repeats     = 8'd4;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (6) step();
        check("rst_mid_in_off_blinker", int'(blinker), 0);
        check("rst_mid_in_off_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_blinker", int'(blinker), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_ready", int'(start_ready), 1);
        step();
        check("rst_mid_no_done", int'(done), 0);
        #2;
        reset_n     = 1'b1;
        on_cycles   = 6'd2;
        off_cycles  = 6'd1;
        repeats     = 8'd1;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        check("post_rst_accept_blinker", int'(blinker), 1);
        step();
        check("post_rst_k2_blinker", int'(blinker), 1);
        step();
        check("post_rst_k3_blinker", int'(blinker), 0);
        check("post_rst_k3_done", int'(done), 0);
        step();
        check("post_rst_k4_done", int'(done), 1);
        step();
        check("post_rst_idle", int'(start_ready), 1);

`ifdef BLINK_CONTROLLER_ABORT_EN
        // abort on the 3rd ON cycle of a 10/10/5 job
        on_cycles   = 6'd10;
        off_cycles  = 6'd10;
        repeats     = 8'd5;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        check("abort_pre_blinker", int'(blinker), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_blinker", int'(blinker), 0);
        check("abort_done", int'(done), 1);
        step();
        check("abort_idle_ready", int'(start_ready), 1);
        check("abort_idle_done", int'(done), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/blink_controller.md
BLINK_CONTROLLER -- requirements
Module: blink_controller

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the on/off phase lengths.
REQ-002 The block SHALL have parameter REP_W, default 8, giving the width of the repeat count.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_valid, input, 1 bit: a job request is present.
REQ-006 The block SHALL have port start_ready, output, 1 bit: the block can accept a job.
REQ-007 The block SHALL have port on_cycles, input, CNT_W bits: high-phase length in clock cycles.
REQ-008 The block SHALL have port off_cycles, input, CNT_W bits: low-phase length in clock cycles.
REQ-009 The block SHALL have port repeats, input, REP_W bits: number of on/off periods in the job.
REQ-010 The block SHALL have port blinker, output, 1 bit: registered blink output.
REQ-011 The block SHALL have port busy, output, 1 bit: a job is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.

Function
REQ-013 The block SHALL implement states IDLE, ON, OFF and DONE.
REQ-014 start_ready SHALL be 1 only in IDLE.
REQ-015 A job SHALL be accepted on a cycle with start_valid=1 and start_ready=1.
- On acceptance the block SHALL latch on_cycles, off_cycles and repeats.
- Input changes after acceptance SHALL have no effect on the running job.
REQ-016 An on_cycles or off_cycles value of 0 SHALL be treated as 1.
REQ-017 After an accept with repeats>0, the block SHALL enter ON on the next edge.
- blinker SHALL be 1 for exactly on_cycles cycles.
- The block SHALL then enter OFF, with blinker=0 for exactly off_cycles cycles.
REQ-018 At the end of OFF, the block SHALL decrement the period counter.
- If periods remain, it SHALL return to ON with no gap cycle.
- Otherwise it SHALL enter DONE.
REQ-019 After an accept with repeats=0, the block SHALL go directly to DONE, and blinker SHALL stay 0.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
- A new job SHALL NOT be accepted in DONE.
REQ-021 busy SHALL be 1 in ON, OFF and DONE, and 0 in IDLE.
REQ-022 blinker SHALL be driven from a flop and SHALL be 1 only in ON.
REQ-023 The phase counter SHALL load (length-1) on phase entry and count down to 0.
- The maximum on/off lengths (2^CNT_W-1) SHALL be exact, with no wrap-around.
REQ-024 start_valid while busy SHALL be ignored, with no queuing.

Reset
REQ-025 When reset_n=0, the block SHALL asynchronously enter IDLE.
- Reset values: blinker=0, busy=0, done=0, start_ready=1, all counters 0.
REQ-026 Reset asserted mid-job SHALL abort the job with no done pulse.
- The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Configuration
REQ-027 The macro BLINK_CONTROLLER_ABORT_EN SHALL control the abort feature.
- When defined: an input port abort (1 bit) SHALL exist.
- abort=1 in ON or OFF SHALL force blinker=0 on the next edge and enter DONE, so done pulses.
- abort in IDLE or DONE SHALL be ignored.
- abort SHALL have priority over phase completion in the same cycle.
REQ-028 When BLINK_CONTROLLER_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and a job always runs to completion.

Verification
REQ-029 Accept on=10, off=10, repeats=20 -> blinker is 0 on the accept cycle, then 1 for 10 cycles and 0 for 10 cycles, 20 times; done pulses once after 400 cycles; busy=1 throughout.
REQ-030 Accept on=0, off=3, repeats=2 -> waveform 1,0,0,0,1,0,0,0, then done=1 for one cycle, then start_ready=1.
REQ-031 Accept repeats=0 -> blinker stays 0 and done pulses on the cycle after accept; start_valid held high -> the next accept occurs only after DONE.
REQ-032 start_valid pulsed with new values mid-job -> ignored; the running waveform is unchanged.
REQ-033 reset_n asserted during OFF of a 5/5/4 job -> all outputs take reset values immediately, with no done pulse.
REQ-034 With BLINK_CONTROLLER_ABORT_EN defined, abort on the 3rd ON cycle of a 10/10/5 job -> blinker=0 next cycle, done pulses, then IDLE.
